// File: rtl/if_reg.sv
// Instruction-fetch stage register: owns the fetch PC, drives the IF bus
// strobe/address and captures the returned word into the IF/ID register.
module if_reg #(
    parameter logic [29:0] RESET_VECTOR = 30'h0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    input  logic        br_taken,
    input  logic [29:0] br_addr,
    input  logic [31:0] insn_in,
    output logic [29:0] if_addr,
    output logic        if_as_,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned PC_W   = 30;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     if_pc_q, if_pc_d;
    logic [INSN_W-1:0]   if_insn_q, if_insn_d;
    logic                if_en_q, if_en_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // State and pipeline register bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            if_pc_q   <= RESET_VECTOR;
            if_insn_q <= NOP_INSN;
            if_en_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            if_pc_q   <= if_pc_d;
            if_insn_q <= if_insn_d;
            if_en_q   <= if_en_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state: redirects squash the slot, stall freezes everything
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        if_pc_d   = if_pc_q;
        if_insn_d = if_insn_q;
        if_en_d   = if_en_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (flush) begin
                    pc_d      = new_pc;
                    if_pc_d   = pc_q;
                    if_insn_d = NOP_INSN;
                    if_en_d   = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (br_taken) begin
                    pc_d      = br_addr;
                    if_pc_d   = pc_q;
                    if_insn_d = NOP_INSN;
                    if_en_d   = 1'b0;
                end else begin
                    pc_d      = pc_q + PC_W'(1);
                    if_pc_d   = pc_q;
                    if_insn_d = insn_in;
                    if_en_d   = 1'b1;
                    cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign if_addr   = pc_q;
    assign if_as_    = (state_q == BOOT) ? 1'b1 : 1'b0;
    assign if_pc     = if_pc_q;
    assign if_insn   = if_insn_q;
    assign if_en     = if_en_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_reg.sv
// Bench for if_reg: directed test-plan scenarios plus random control traffic,
// all outputs compared against a behavioural fetch model every cycle.
module tb_if_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, br_taken;
    logic [29:0] new_pc, br_addr;
    logic [31:0] insn_in;
    logic [29:0] if_addr, if_pc;
    logic        if_as_, if_en;
    logic [31:0] if_insn, fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_boot;
    longint      m_pc, m_ifpc, m_cnt;
    logic [31:0] m_insn;
    bit          m_en;
    logic [31:0] saved_cnt;

    if_reg dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .new_pc   (new_pc),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .insn_in  (insn_in),
        .if_addr  (if_addr),
        .if_as_   (if_as_),
        .if_pc    (if_pc),
        .if_insn  (if_insn),
        .if_en    (if_en),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = 0;
        m_ifpc = 0;
        m_insn = NOP;
        m_en   = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (flush) begin
            m_ifpc = m_pc;
            m_pc   = longint'(new_pc);
            m_insn = NOP;
            m_en   = 1'b0;
        end else if (stall) begin
            m_boot = 1'b0;
        end else if (br_taken) begin
            m_ifpc = m_pc;
            m_pc   = longint'(br_addr);
            m_insn = NOP;
            m_en   = 1'b0;
        end else begin
            m_ifpc = m_pc;
            m_insn = insn_in;
            m_en   = 1'b1;
            m_pc   = (m_pc + 1) % (64'd1 << 30);
            m_cnt  = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".if_addr"},   64'(if_addr),   64'(m_pc));
        chk({tag, ".if_as_"},    64'(if_as_),    64'(m_boot));
        chk({tag, ".if_pc"},     64'(if_pc),     64'(m_ifpc));
        chk({tag, ".if_insn"},   64'(if_insn),   64'(m_insn));
        chk({tag, ".if_en"},     64'(if_en),     64'(m_en));
        chk({tag, ".fetch_cnt"}, 64'(fetch_cnt), 64'(m_cnt));
    endtask

    // drive one cycle of inputs, clock it through model and DUT, then compare
    task automatic step(input string tag, input logic s, input logic f, input logic b,
                        input logic [29:0] np, input logic [29:0] ba, input logic [31:0] ins);
        stall = s; flush = f; br_taken = b; new_pc = np; br_addr = ba; insn_in = ins;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic run_normal(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 30'h0, 30'h0, 32'hA000_0000 + 32'(m_pc));
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        new_pc = '0; br_addr = '0; insn_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst_hold");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) run_normal("pre");

        // asynchronous reset mid-cycle during a stall
        stall = 1'b1;
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        #1 check_all("boot");
        chk("boot_as", 64'(if_as_), 64'd1);
        step("boot_ignore", 1'b1, 1'b1, 1'b1, 30'h55, 30'h66, 32'hDEAD_BEEF);
        chk("run_as", 64'(if_as_), 64'd0);
        chk("run_addr0", 64'(if_addr), 64'd0);

        // sequential fetch
        for (int i = 0; i < 4; i++) begin
            run_normal("seq");
            chk("seq_pc", 64'(if_pc), 64'(i));
            chk("seq_insn", 64'(if_insn), 64'(32'hA000_0000 + 32'(i)));
        end
        chk("seq_cnt", 64'(fetch_cnt), 64'd4);

        // stall at pc=5
        run_normal("to5");
        saved_cnt = fetch_cnt;
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 1'b0, 1'b0, 30'h0, 30'h0, 32'h0);
            chk("stall_addr", 64'(if_addr), 64'd5);
            chk("stall_cnt", 64'(fetch_cnt), 64'(saved_cnt));
        end
        run_normal("resume");
        chk("resume_pc", 64'(if_pc), 64'd5);
        chk("resume_insn", 64'(if_insn), 64'hA000_0005);

        // taken branch at pc=8
        run_normal("to7");
        run_normal("to8");
        chk("br_at8", 64'(if_addr), 64'd8);
        step("branch", 1'b0, 1'b0, 1'b1, 30'h0, 30'h100, 32'hA000_0008);
        chk("br_en", 64'(if_en), 64'd0);
        chk("br_insn", 64'(if_insn), 64'(NOP));
        chk("br_addr", 64'(if_addr), 64'h100);
        run_normal("br_tgt");
        chk("br_tgt_pc", 64'(if_pc), 64'h100);

        // flush beats stall and branch
        saved_cnt = fetch_cnt;
        step("flush_all", 1'b1, 1'b1, 1'b1, 30'h40, 30'h80, 32'h0);
        chk("flush_addr", 64'(if_addr), 64'h40);
        chk("flush_en", 64'(if_en), 64'd0);
        chk("flush_cnt", 64'(fetch_cnt), 64'(saved_cnt));
        step("br_after_flush", 1'b0, 1'b0, 1'b1, 30'h0, 30'h200, 32'h1234_5678);
        chk("baf_addr", 64'(if_addr), 64'h200);

        // pc wrap-around
        step("flush_wrap", 1'b0, 1'b1, 1'b0, 30'h3FFF_FFFF, 30'h0, 32'h0);
        run_normal("wrap1");
        chk("wrap1_pc", 64'(if_pc), 64'h3FFF_FFFF);
        run_normal("wrap2");
        chk("wrap2_pc", 64'(if_pc), 64'h0);

        // randomized control traffic
        for (int i = 0; i < 400; i++) begin
            logic s, f, b;
            logic [29:0] np;
            s  = ($urandom % 5) == 0;
            f  = ($urandom % 11) == 0;
            b  = ($urandom % 7) == 0;
            np = ($urandom % 4 == 0) ? 30'h3FFF_FFFE : 30'($urandom);
            step("rand", s, f, b, np, 30'($urandom), s ? 32'h0 : $urandom);
        end

        // counter saturation
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1 release dut.cnt_q;
        m_cnt = 64'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) run_normal("sat");
        chk("sat_cnt", 64'(fetch_cnt), 64'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
